// File: rtl/mrelbp_code_histogram_if.sv
// Beat-input and bin-output handshake bundle for mrelbp_code_histogram.
// The master drives beats and bin_ready; the slave is the histogram itself.
interface mrelbp_code_histogram_if #(
  parameter int LANES  = 25,
  parameter int CODE_W = 1,
  parameter int CNT_W  = 24
);
  logic                    i_sof;
  logic                    i_valid;
  logic [LANES*CODE_W-1:0] i_codes;
  logic                    i_eof;
  logic                    o_ready;
  logic                    o_bin_valid;
  logic [CODE_W-1:0]       o_bin_idx;
  logic [CNT_W-1:0]        o_bin_cnt;
  logic                    i_bin_ready;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_sat;

  modport master (
    output i_sof, i_valid, i_codes, i_eof, i_bin_ready,
    input  o_ready, o_bin_valid, o_bin_idx, o_bin_cnt, o_busy, o_done, o_sat
  );

  modport slave (
    input  i_sof, i_valid, i_codes, i_eof, i_bin_ready,
    output o_ready, o_bin_valid, o_bin_idx, o_bin_cnt, o_busy, o_done, o_sat
  );
endinterface

// File: rtl/mrelbp_code_histogram.sv
// Frame-based MRELBP code histogram: per-beat multi-lane binning, saturating
// counters, serial bin drain. Define HIST_FLAT_OUT_EN for the parallel o_bins readout.
module mrelbp_code_histogram #(
  parameter int LANES  = 25,
  parameter int CODE_W = 1,
  parameter int CNT_W  = 24
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  mrelbp_code_histogram_if.slave        bus
`ifdef HIST_FLAT_OUT_EN
  ,
  output logic [(2**CODE_W)*CNT_W-1:0]  o_bins
`endif
);

  localparam int NBINS = 2**CODE_W;
  localparam int INC_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NBINS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bin_q    [NBINS];
  logic [CNT_W-1:0]  bin_next [NBINS];
  logic [CNT_W:0]    bin_sum  [NBINS];
  logic [INC_W-1:0]  inc      [NBINS];
  logic [NBINS-1:0]  bin_clamp;
  logic [CODE_W-1:0] idx_q;
  logic              done_q;
  logic              sat_q;
  logic              clear;
  logic              accept;
  logic              drain_hs;
  logic              last_hs;

  // sof wins over a same-cycle beat and is only honoured outside DRAIN.
  assign clear    = bus.i_sof && (state_q == IDLE || state_q == ACC);
  assign accept   = (state_q == ACC) && bus.i_valid && !bus.i_sof;
  assign drain_hs = (state_q == DRAIN) && bus.i_bin_ready;
  assign last_hs  = drain_hs && (idx_q == LAST_IDX);

  // Per-bin lane population count for the current beat.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      // NOTE: every combinationally assigned variable gets a default before any
      // conditional update, otherwise synthesis infers a latch to hold it.
      inc[b] = '0;
      for (int n = 0; n < LANES; n++) begin
        if (bus.i_codes[n*CODE_W +: CODE_W] == CODE_W'(b)) begin
          inc[b] = inc[b] + INC_W'(1);
        end
      end
    end
  end

  // Widened add then clamp: counters stick at all-ones instead of wrapping.
  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      bin_sum[b]   = {1'b0, bin_q[b]} + (CNT_W+1)'(inc[b]);
      bin_clamp[b] = bin_sum[b][CNT_W];
      bin_next[b]  = bin_clamp[b] ? CNT_MAX : bin_sum[b][CNT_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.i_sof) state_d = ACC;
      ACC:   if (!bus.i_sof && bus.i_valid && bus.i_eof) state_d = DRAIN;
      DRAIN: if (last_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.o_ready     = (state_q == ACC);
    bus.o_bin_valid = (state_q == DRAIN);
    bus.o_busy      = (state_q != IDLE);
    bus.o_bin_idx   = idx_q;
    bus.o_bin_cnt   = (state_q == DRAIN) ? bin_q[idx_q] : '0;
    bus.o_done      = done_q;
    bus.o_sat       = sat_q;
  end

  // Bin array, drain index and status flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the bin array is reset explicitly because it is architecturally
      // visible (drain and flat readout) and must read zero after an abort.
      for (int b = 0; b < NBINS; b++) begin
        bin_q[b] <= '0;
      end
      idx_q  <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      done_q <= last_hs;

      if (clear) begin
        for (int b = 0; b < NBINS; b++) begin
          bin_q[b] <= '0;
        end
        sat_q <= 1'b0;
      end else if (accept) begin
        for (int b = 0; b < NBINS; b++) begin
          bin_q[b] <= bin_next[b];
        end
        if (|bin_clamp) sat_q <= 1'b1;
      end

      // Index wraps to zero naturally after the last bin.
      if (drain_hs) begin
        idx_q <= last_hs ? '0 : idx_q + CODE_W'(1);
      end
    end
  end

`ifdef HIST_FLAT_OUT_EN
  for (genvar g = 0; g < NBINS; g++) begin : g_flat
    assign o_bins[g*CNT_W +: CNT_W] = bin_q[g];
  end
`endif

endmodule

// File: doc/mrelbp_code_histogram.md
Name: mrelbp_code_histogram

Overview:
- Frame-based histogram accumulator for MRELBP code streams. It generalises the fixed 2-bin CI counter to NBINS = 2**CODE_W bins.
- Each beat carries LANES codes. Every bin is incremented by the number of lanes whose code equals that bin's index.
- At end of frame the bins are streamed out serially with a valid/ready handshake to the feature-vector assembler.
- With CODE_W=1 it is the CI histogram: bin0 counts zeros, bin1 counts ones.

Parameters:
- LANES, 25, codes per input beat
- CODE_W, 1, bits per code; NBINS = 2**CODE_W (derived localparam)
- CNT_W, 24, width of each bin counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_sof  in  1  start of frame; clears bins
- i_valid  in  1  input beat valid
- i_codes  in  LANES*CODE_W  packed codes; lane n = bits [n*CODE_W +: CODE_W]
- i_eof  in  1  last beat of frame; qualified by i_valid & o_ready
- o_ready  out  1  accepting beats (high only in ACC)
- o_bin_valid  out  1  bin output valid (DRAIN)
- o_bin_idx  out  CODE_W  index of presented bin
- o_bin_cnt  out  CNT_W  count of presented bin
- i_bin_ready  in  1  downstream accepts bin
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after last bin handshake
- o_sat  out  1  sticky: some bin saturated this frame

Behaviour:
- Reset: all bins 0, drain index 0, state IDLE. o_ready=0, o_bin_valid=0, o_bin_idx=0, o_bin_cnt=0, o_busy=0, o_done=0, o_sat=0. Reset mid-operation aborts the frame immediately.
- FSM states: IDLE, ACC, DRAIN.
- IDLE:
  - o_ready=0; beats are ignored.
  - i_sof: clear all bins and o_sat at that edge, go to ACC. o_ready rises the next cycle.
- ACC:
  - A beat is accepted when i_valid & o_ready.
  - At the accepting edge, bin[b] <= bin[b] + inc[b], where inc[b] = number of lanes with code == b (width clog2(LANES+1)). Zero-latency update: bin registers reflect the beat after that edge.
  - Accepted beat with i_eof: update bins, go to DRAIN, drain index = 0.
  - i_sof in ACC: clear bins and o_sat, stay in ACC, discard any same-cycle beat (sof wins).
  - Beat without i_valid: no change.
- DRAIN:
  - o_ready=0 and o_bin_valid=1.
  - o_bin_idx = drain index; o_bin_cnt = bin[drain index], combinational mux of registered bins.
  - On i_bin_ready, the index increments. Held stable while i_bin_ready=0.
  - After the handshake of index NBINS-1: o_done=1 for exactly the next cycle, go to IDLE, index resets to 0.
  - i_sof ignored in DRAIN.
- Arithmetic:
  - Sum computed at CNT_W+1 bits.
  - If it exceeds 2**CNT_W-1, the bin clamps to 2**CNT_W-1 and o_sat sets. o_sat stays set until the next i_sof or reset.
  - No wrap-around ever.
- Bins retain their values in IDLE after drain until the next i_sof.
- Sum of all bins equals LANES × accepted beats unless saturated.

Optional Feature:
- Macro HIST_FLAT_OUT_EN.
- Defined:
  - Extra output port o_bins, NBINS*CNT_W bits. Bin b is at [b*CNT_W +: CNT_W].
  - Continuously driven from the bin registers in all states, as a legacy parallel readout.
  - Reset value 0.
- Undefined: port absent; bins readable only through DRAIN.
- Core behaviour is identical either way.

Test Plan:
- Defaults: sof; one beat i_codes=25'h00003FF with eof -> DRAIN presents idx0 cnt15, idx1 cnt10 (i_bin_ready=1); o_done pulses once; back to IDLE.
- Defaults: beats 25'h1FFFFFF, 25'h0000000, 25'h1555555 (eof on third) -> bin0=37, bin1=38; o_sat=0.
- Backpressure: in DRAIN hold i_bin_ready=0 for 5 cycles -> o_bin_idx=0, o_bin_cnt stable. Raise ready -> idx1 next cycle; o_done only after idx1 handshake.
- CNT_W=5: two beats of all ones -> bin1=31 (clamped), bin0=0, o_sat=1. Next i_sof clears o_sat and bins.
- CODE_W=2, LANES=4: lane codes {0,1,1,3}, then sof mid-ACC plus repeat with eof -> bins {1,2,0,1}; the pre-sof beat does not contribute.
- Async reset mid-ACC after two beats -> all outputs 0 immediately, state IDLE; a subsequent beat without sof is ignored.
